// File: rtl/register_file_banked.sv
// register_file_banked
//
// Parametrised register file for the pebble datapath: three combinational read
// ports, one synchronous write port, optional write-to-read bypass, optional
// hardwired-zero register 0, and a one-deep shadow bank that saves or restores
// the whole register set in a single cycle.
//
// Parameters
//   WIDTH    register width in bits
//   DEPTH    number of registers (>= 2); AW = $clog2(DEPTH) is derived
//   BYPASS   1: a same-cycle effective write is forwarded to matching reads
//   ZERO_REG 1: register 0 reads as 0 and writes to it are ignored
//
// Ports
//   clk            clock, all state updates on posedge
//   reset          synchronous, active-high
//   write_enable   write request this cycle
//   write_addr     write register index
//   write_data     write value
//   read_a/b/c     read addresses (r0 field, r1 field, branch target)
//   read_a/b/c_data combinational read data
//   save           snapshot the register set into the shadow bank
//   restore        copy the shadow bank back (only when shadow_valid)
//   shadow_valid   shadow bank holds an unconsumed snapshot
//   write_dropped  1-cycle pulse: previous cycle's write lost to a restore
module register_file_banked #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_enable,
    input  logic [AW-1:0]    write_addr,
    input  logic [WIDTH-1:0] write_data,
    input  logic [AW-1:0]    read_a,
    input  logic [AW-1:0]    read_b,
    input  logic [AW-1:0]    read_c,
    output logic [WIDTH-1:0] read_a_data,
    output logic [WIDTH-1:0] read_b_data,
    output logic [WIDTH-1:0] read_c_data,
    input  logic             save,
    input  logic             restore,
    output logic             shadow_valid,
    output logic             write_dropped
);

    logic [WIDTH-1:0] r_core   [DEPTH];
    logic [WIDTH-1:0] r_shadow [DEPTH];
    logic             r_shadow_valid;
    logic             r_write_dropped;

    logic             w_restore_acc;
    logic             w_write_req;
    logic             w_eff_write;
    logic             w_bypass;
    logic [WIDTH-1:0] w_core_next [DEPTH];
    logic [AW-1:0]    w_raddr     [3];
    logic [WIDTH-1:0] w_rdata     [3];

    assign w_restore_acc = restore && r_shadow_valid;

    // A write that would land in a real register; out-of-range and zero-register
    // writes are dropped silently and never count as "discarded".
    assign w_write_req = write_enable && (32'(write_addr) < DEPTH) &&
                         !(ZERO_REG && (write_addr == '0));
    assign w_eff_write = w_write_req && !w_restore_acc;
    assign w_bypass    = BYPASS && w_eff_write && !reset;

    // Post-write register contents; also the source of a same-cycle save so the
    // snapshot includes the write.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_core_next[i] = r_core[i];
            if (w_eff_write && (write_addr == AW'(i))) begin
                w_core_next[i] = write_data;
            end
        end
    end

    assign w_raddr[0] = read_a;
    assign w_raddr[1] = read_b;
    assign w_raddr[2] = read_c;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            w_rdata[p] = '0;
            if (ZERO_REG && (w_raddr[p] == '0)) begin
                w_rdata[p] = '0;
            end else if (32'(w_raddr[p]) >= DEPTH) begin
                w_rdata[p] = '0;
            end else if (w_bypass && (write_addr == w_raddr[p])) begin
                w_rdata[p] = write_data;
            end else begin
                w_rdata[p] = r_core[w_raddr[p]];
            end
        end
    end

    assign read_a_data   = w_rdata[0];
    assign read_b_data   = w_rdata[1];
    assign read_c_data   = w_rdata[2];
    assign shadow_valid  = r_shadow_valid;
    assign write_dropped = r_write_dropped;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_core[i]   <= '0;
                r_shadow[i] <= '0;
            end
            r_shadow_valid  <= 1'b0;
            r_write_dropped <= 1'b0;
        end else begin
            r_write_dropped <= w_restore_acc && w_write_req;
            if (w_restore_acc) begin
                // Restore wins over both write and save.
                for (int i = 0; i < int'(DEPTH); i++) begin
                    r_core[i] <= r_shadow[i];
                end
                r_shadow_valid <= 1'b0;
            end else begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    r_core[i] <= w_core_next[i];
                end
                if (save) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        r_shadow[i] <= w_core_next[i];
                    end
                    r_shadow_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file_banked.sv
// Scoreboard bench for register_file_banked. Four configurations share one
// stimulus stream: u0 defaults, u1 no bypass + zero register, u2 16-bit with a
// non-power-of-two depth (addresses 6,7 out of range), u3 16-bit x 8 no bypass
// + zero register.
module tb_register_file_banked;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_rst = 1'b1;
    logic        s_we = 1'b0;
    logic [2:0]  s_wa = '0;
    logic [15:0] s_wd = '0;
    logic [2:0]  s_ra = '0, s_rb = '0, s_rc = '0;
    logic        s_save = 1'b0, s_restore = 1'b0;

    logic [7:0]  a0, b0, c0, a1, b1, c1;
    logic [15:0] a2, b2, c2, a3, b3, c3;
    logic [3:0]  osv, owd;
    logic [15:0] oa [4];
    logic [15:0] ob [4];
    logic [15:0] oc [4];

    register_file_banked u0 (
        .clk(clk), .reset(s_rst), .write_enable(s_we), .write_addr(s_wa[1:0]),
        .write_data(s_wd[7:0]), .read_a(s_ra[1:0]), .read_b(s_rb[1:0]), .read_c(s_rc[1:0]),
        .read_a_data(a0), .read_b_data(b0), .read_c_data(c0), .save(s_save),
        .restore(s_restore), .shadow_valid(osv[0]), .write_dropped(owd[0])
    );
    register_file_banked #(.BYPASS(1'b0), .ZERO_REG(1'b1)) u1 (
        .clk(clk), .reset(s_rst), .write_enable(s_we), .write_addr(s_wa[1:0]),
        .write_data(s_wd[7:0]), .read_a(s_ra[1:0]), .read_b(s_rb[1:0]), .read_c(s_rc[1:0]),
        .read_a_data(a1), .read_b_data(b1), .read_c_data(c1), .save(s_save),
        .restore(s_restore), .shadow_valid(osv[1]), .write_dropped(owd[1])
    );
    register_file_banked #(.WIDTH(16), .DEPTH(6)) u2 (
        .clk(clk), .reset(s_rst), .write_enable(s_we), .write_addr(s_wa),
        .write_data(s_wd), .read_a(s_ra), .read_b(s_rb), .read_c(s_rc),
        .read_a_data(a2), .read_b_data(b2), .read_c_data(c2), .save(s_save),
        .restore(s_restore), .shadow_valid(osv[2]), .write_dropped(owd[2])
    );
    register_file_banked #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0), .ZERO_REG(1'b1)) u3 (
        .clk(clk), .reset(s_rst), .write_enable(s_we), .write_addr(s_wa),
        .write_data(s_wd), .read_a(s_ra), .read_b(s_rb), .read_c(s_rc),
        .read_a_data(a3), .read_b_data(b3), .read_c_data(c3), .save(s_save),
        .restore(s_restore), .shadow_valid(osv[3]), .write_dropped(owd[3])
    );

    assign oa[0] = {8'h00, a0};
    assign ob[0] = {8'h00, b0};
    assign oc[0] = {8'h00, c0};
    assign oa[1] = {8'h00, a1};
    assign ob[1] = {8'h00, b1};
    assign oc[1] = {8'h00, c1};
    assign oa[2] = a2;
    assign ob[2] = b2;
    assign oc[2] = c2;
    assign oa[3] = a3;
    assign ob[3] = b3;
    assign oc[3] = c3;

    // Configuration table for the reference model
    int C_W  [4] = '{8, 8, 16, 16};
    int C_D  [4] = '{4, 4, 6, 8};
    int C_AW [4] = '{2, 2, 3, 3};
    bit C_B  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit C_Z  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reference model state
    logic [15:0] m_core   [4][8];
    logic [15:0] m_shadow [4][8];
    bit          m_sv [4];
    bit          m_wd [4];

    typedef struct packed {
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [3:0][15:0] c;
        logic [3:0]       sv;
        logic [3:0]       wd;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic logic [15:0] wmask(int k);
        return (C_W[k] == 16) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic int aidx(int k, logic [2:0] a);
        return (C_AW[k] == 2) ? int'(a[1:0]) : int'(a);
    endfunction

    function automatic bit m_write_req(int k);
        int wa = aidx(k, s_wa);
        return s_we && (wa < C_D[k]) && !(C_Z[k] && wa == 0);
    endfunction

    function automatic logic [15:0] m_read(int k, logic [2:0] raddr);
        int a = aidx(k, raddr);
        bit acc = s_restore && m_sv[k];
        if (C_Z[k] && a == 0) return 16'h0;
        if (a >= C_D[k]) return 16'h0;
        if (!s_rst && C_B[k] && m_write_req(k) && !acc && aidx(k, s_wa) == a)
            return s_wd & wmask(k);
        return m_core[k][a];
    endfunction

    function automatic void m_update(int k);
        bit acc = s_restore && m_sv[k];
        bit req = m_write_req(k);
        if (s_rst) begin
            for (int i = 0; i < 8; i++) begin
                m_core[k][i] = 16'h0;
                m_shadow[k][i] = 16'h0;
            end
            m_sv[k] = 1'b0;
            m_wd[k] = 1'b0;
        end else begin
            m_wd[k] = acc && req;
            if (acc) begin
                for (int i = 0; i < 8; i++) m_core[k][i] = m_shadow[k][i];
                m_sv[k] = 1'b0;
            end else begin
                if (req) m_core[k][aidx(k, s_wa)] = s_wd & wmask(k);
                if (s_save) begin
                    for (int i = 0; i < 8; i++) m_shadow[k][i] = m_core[k][i];
                    m_sv[k] = 1'b1;
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: retire the previous inputs into the model at the edge, then
    // drive new inputs and queue the responses they should produce.
    task automatic step(input bit r, input bit we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rc,
                        input bit sv, input bit rs);
        exp_t e;
        @(posedge clk);
        for (int k = 0; k < 4; k++) m_update(k);
        #1;
        s_rst = r; s_we = we; s_wa = wa; s_wd = wd;
        s_ra = ra; s_rb = rb; s_rc = rc; s_save = sv; s_restore = rs;
        for (int k = 0; k < 4; k++) begin
            e.a[k]  = m_read(k, s_ra);
            e.b[k]  = m_read(k, s_rb);
            e.c[k]  = m_read(k, s_rc);
            e.sv[k] = m_sv[k];
            e.wd[k] = m_wd[k];
        end
        q.push_back(e);
    endtask

    task automatic rd(input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rc);
        step(1'b0, 1'b0, 3'd0, 16'h0, ra, rb, rc, 1'b0, 1'b0);
    endtask

    // Monitor: compare whatever the driver queued against the live outputs
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            for (int k = 0; k < 4; k++) begin
                check($sformatf("u%0d.read_a_data", k), oa[k], e.a[k]);
                check($sformatf("u%0d.read_b_data", k), ob[k], e.b[k]);
                check($sformatf("u%0d.read_c_data", k), oc[k], e.c[k]);
                check($sformatf("u%0d.shadow_valid", k), {15'h0, osv[k]}, {15'h0, e.sv[k]});
                check($sformatf("u%0d.write_dropped", k), {15'h0, owd[k]}, {15'h0, e.wd[k]});
            end
        end
    end

    initial begin
        // Reset, then all ports read zero
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd3, 3'd4, 3'd5, 1'b0, 1'b0);
        rd(3'd0, 3'd1, 3'd3);
        @(negedge clk);
        check("rst_read_a", oa[0], 16'h0);
        check("rst_read_c", oc[3], 16'h0);
        check("rst_shadow_valid", {15'h0, osv[0]}, 16'h0);

        // Write r2=A5: bypass on u0, old value on u1 until next cycle
        step(1'b0, 1'b1, 3'd2, 16'h00A5, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("bypass_same_cycle", oa[0], 16'h00A5);
        check("nobypass_same_cycle", oa[1], 16'h0000);
        rd(3'd2, 3'd0, 3'd0);
        @(negedge clk);
        check("nobypass_next_cycle", oa[1], 16'h00A5);

        // Save with concurrent write, overwrite, restore
        step(1'b0, 1'b1, 3'd1, 16'h0011, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd3, 16'h0033, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd0, 16'h007F, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd1, 16'h00EE, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd1, 3'd3, 1'b0, 1'b1);
        rd(3'd0, 3'd1, 3'd3);
        @(negedge clk);
        check("restore_r0", oa[0], 16'h007F);
        check("restore_r1", ob[0], 16'h0011);
        check("restore_r3", oc[0], 16'h0033);
        check("restore_zero_r0", oa[1], 16'h0000);
        check("restore_consumes", {15'h0, osv[0]}, 16'h0);

        // Restore + write while shadow valid: write discarded, 1-cycle pulse
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd2, 16'h0055, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        check("restore_cycle_no_bypass", oa[0], 16'h00A5);
        rd(3'd2, 3'd0, 3'd0);
        @(negedge clk);
        check("dropped_r2_keeps_shadow", oa[0], 16'h00A5);
        check("dropped_pulse", {15'h0, owd[0]}, 16'h0001);
        rd(3'd2, 3'd0, 3'd0);
        @(negedge clk);
        check("dropped_pulse_ends", {15'h0, owd[0]}, 16'h0);
        // Same again with no snapshot: write proceeds
        step(1'b0, 1'b1, 3'd2, 16'h0055, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        check("noop_restore_bypass", oa[0], 16'h0055);
        rd(3'd2, 3'd0, 3'd0);
        @(negedge clk);
        check("noop_restore_write", oa[0], 16'h0055);
        check("noop_restore_no_drop", {15'h0, owd[0]}, 16'h0);

        // Zero register ignores writes
        step(1'b0, 1'b1, 3'd0, 16'h00FF, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("zero_reg_same", oa[1], 16'h0);
        rd(3'd0, 3'd0, 3'd0);
        @(negedge clk);
        check("zero_reg_next", oa[1], 16'h0);
        check("zero_reg_no_drop", {15'h0, owd[1]}, 16'h0);

        // 16-bit x 8: r7 works; on the 6-deep instance r7 is out of range
        step(1'b0, 1'b1, 3'd7, 16'hBEEF, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0);
        @(negedge clk);
        check("oor_read_bypass", oc[2], 16'h0);
        rd(3'd0, 3'd0, 3'd7);
        @(negedge clk);
        check("wide_r7", oc[3], 16'hBEEF);
        check("oor_read", oc[2], 16'h0);

        // Reset during save + write
        step(1'b0, 1'b1, 3'd1, 16'h0042, 3'd1, 3'd0, 3'd0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 3'd1, 16'h0099, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
        rd(3'd1, 3'd2, 3'd3);
        @(negedge clk);
        check("midrst_r1", oa[0], 16'h0);
        check("midrst_shadow_valid", {15'h0, osv[0]}, 16'h0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1);
        rd(3'd1, 3'd2, 3'd7);
        @(negedge clk);
        check("midrst_restore_noop", ob[0], 16'h0);
        check("midrst_restore_wide", oc[3], 16'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
                 3'($urandom_range(0, 7)), 16'($urandom),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
        end
        rd(3'd0, 3'd0, 3'd0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
